// File: rtl/rfu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rfu_pipe
// Description : Pipelined register file unit placed between decode and ALU.
//               Two registered read ports, one write port and a per-register
//               busy scoreboard. A read whose sources have pending loads is
//               stalled until the load result is written back.
//               Optional feature macro: RFU_BYPASS_EN. When it is defined,
//               same-cycle write data is forwarded to the read ports and also
//               satisfies the busy check.
// Revision    : 1.0 - initial release
// ============================================================================
module rfu_pipe #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int ZERO_REG    = 1,
    parameter int RESET_INDEX = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rs1_addr,
    input  logic [ADDR_W-1:0]       rs2_addr,
    output logic [DATA_W-1:0]       rs1_data,
    output logic [DATA_W-1:0]       rs2_data,
    output logic                    rd_valid,
    output logic                    stall,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    claim_en,
    input  logic [ADDR_W-1:0]       claim_addr,
    output logic [(2**ADDR_W)-1:0]  busy_vec
);

    localparam int   c_depth   = 2 ** ADDR_W;
    localparam logic c_zero_en = (ZERO_REG != 0);

    // Reset contents of register idx: its own index, or zero.
    function automatic logic [DATA_W-1:0] f_rst_val(input int idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if (RESET_INDEX != 0) begin
            v = DATA_W'(idx);
        end
        return v;
    endfunction

    logic [c_depth-1:0][DATA_W-1:0] r_regs;
    logic [c_depth-1:0]             r_busy;
    logic [DATA_W-1:0]              r_rs1_data;
    logic [DATA_W-1:0]              r_rs2_data;
    logic                           r_rd_valid;

    logic                           w_wr_eff;
    logic                           w_claim_eff;
    logic                           w_rs1_zero;
    logic                           w_rs2_zero;
    logic                           w_fwd1;
    logic                           w_fwd2;
    logic                           w_rs1_rdy;
    logic                           w_rs2_rdy;
    logic                           w_rd_acc;
    logic [DATA_W-1:0]              w_rs1_val;
    logic [DATA_W-1:0]              w_rs2_val;

    // Register 0 is hardwired when ZERO_REG is set: drop its writes and claims.
    assign w_wr_eff    = wr_en    & ~(c_zero_en & (wr_addr    == '0));
    assign w_claim_eff = claim_en & ~(c_zero_en & (claim_addr == '0));
    assign w_rs1_zero  = c_zero_en & (rs1_addr == '0);
    assign w_rs2_zero  = c_zero_en & (rs2_addr == '0);

`ifdef RFU_BYPASS_EN
    assign w_fwd1 = w_wr_eff & (wr_addr == rs1_addr);
    assign w_fwd2 = w_wr_eff & (wr_addr == rs2_addr);
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    // A source is ready when no load is pending, or its result is forwarded now.
    assign w_rs1_rdy = ~r_busy[rs1_addr] | w_fwd1;
    assign w_rs2_rdy = ~r_busy[rs2_addr] | w_fwd2;

    assign stall    = rd_en & (~w_rs1_rdy | ~w_rs2_rdy);
    assign w_rd_acc = rd_en & ~stall;

    assign w_rs1_val = w_rs1_zero ? '0 : (w_fwd1 ? wr_data : r_regs[rs1_addr]);
    assign w_rs2_val = w_rs2_zero ? '0 : (w_fwd2 ? wr_data : r_regs[rs2_addr]);

    // Register storage: reset image, then single write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_regs[i] <= (c_zero_en && i == 0) ? '0 : f_rst_val(i);
            end
        end else if (w_wr_eff) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Busy scoreboard: a write clears, a claim sets; the claim is applied last so it wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            if (w_wr_eff) begin
                r_busy[wr_addr] <= 1'b0;
            end
            if (w_claim_eff) begin
                r_busy[claim_addr] <= 1'b1;
            end
        end
    end

    // Read pipeline stage: capture operands of an accepted read, hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rs1_data <= w_rs1_val;
                r_rs2_data <= w_rs2_val;
            end
        end
    end

    assign rs1_data = r_rs1_data;
    assign rs2_data = r_rs2_data;
    assign rd_valid = r_rd_valid;
    assign busy_vec = r_busy;

endmodule
`default_nettype wire
